// File: rtl/signature_learner_pkg.sv
// rtl/signature_learner_pkg.sv - shared parameters, entry layout, flags and FSM encoding for the ETS signature learner
package signature_learner_pkg;
  localparam int N_ENTRIES   = 64;
  localparam int ID_W        = 6;
  localparam int CYC_W       = 16;
  localparam int CNT_W       = 8;
  localparam int MIN_SAMPLES = 4;
  localparam int MARGIN      = 2;

  localparam int TOL_W     = 8;
  localparam int FLAG_W    = 8;
  localparam int DATA_W    = 32;
  localparam int EXP_LSB   = 16;
  localparam int TOL_LSB   = 8;
  localparam int FLAGS_LSB = 0;

  localparam logic [FLAG_W-1:0] FLAG_ENABLE  = 8'h01;
  localparam logic [FLAG_W-1:0] FLAG_TOL_SAT = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LEARN  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Packed so that the struct bit layout is exactly the DB word layout.
  typedef struct packed {
    logic [CYC_W-1:0]  expected;
    logic [TOL_W-1:0]  tol;
    logic [FLAG_W-1:0] flags;
  } entry_t;
endpackage

// File: rtl/signature_learner_if.sv
// rtl/signature_learner_if.sv - sample input stream and signature DB write port bundle
interface signature_learner_if;
  import signature_learner_pkg::*;

  logic             sample_valid;
  logic [ID_W-1:0]  sample_id;
  logic [CYC_W-1:0] sample_cycles;
  logic             sample_ready;
  logic             wr_en;
  logic [ID_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output sample_valid, sample_id, sample_cycles,
    input  sample_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  sample_valid, sample_id, sample_cycles,
    output sample_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/signature_learner_calc.sv
// rtl/signature_learner_calc.sv - combinational min/max to {expected, tolerance, flags} conversion
module signature_calc
  import signature_learner_pkg::*;
(
  input  logic [CYC_W-1:0] i_min,
  input  logic [CYC_W-1:0] i_max,
  output entry_t           o_entry
);
  logic [CYC_W:0]   w_sum;
  logic [CYC_W-1:0] w_expected;
  logic [CYC_W-1:0] w_half;
  logic [CYC_W:0]   w_tol_full;
  logic             w_sat;

  always_comb begin
    w_sum      = {1'b0, i_min} + {1'b0, i_max};
    w_expected = w_sum[CYC_W:1];
    w_half     = i_max - w_expected;
    w_tol_full = {1'b0, w_half} + (CYC_W+1)'(MARGIN);
    w_sat      = (w_tol_full > (CYC_W+1)'(255));

    o_entry.expected = w_expected;
    o_entry.tol      = w_sat ? 8'hFF : w_tol_full[TOL_W-1:0];
    o_entry.flags    = FLAG_ENABLE | (w_sat ? FLAG_TOL_SAT : 8'h00);
  end
endmodule

// File: rtl/signature_learner.sv
// rtl/signature_learner.sv - training-window statistics collector and signature DB commit engine
module signature_learner
  import signature_learner_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              learn_start,
  input  logic              learn_stop,
  signature_learner_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic [ID_W:0]     commit_count
);
  state_t r_state;
  state_t w_next;

  logic [ID_W-1:0]  r_idx;
  logic [CYC_W-1:0] r_min [N_ENTRIES];
  logic [CYC_W-1:0] r_max [N_ENTRIES];
  logic [CNT_W-1:0] r_cnt [N_ENTRIES];

  logic             r_wr_en;
  logic [ID_W-1:0]  r_wr_addr;
  entry_t           r_wr_data;
  logic             r_done;
  logic [ID_W:0]    r_commit_count;

  logic             w_last_idx;
  logic             w_accept;
  logic             w_hit;
  entry_t           w_entry;

  assign w_last_idx = (r_idx == ID_W'(N_ENTRIES - 1));
  assign w_accept   = (r_state == ST_LEARN) && bus.sample_valid;
  assign w_hit      = (r_state == ST_COMMIT) && (r_cnt[r_idx] >= CNT_W'(MIN_SAMPLES));

  signature_calc u_calc (
    .i_min   (r_min[r_idx]),
    .i_max   (r_max[r_idx]),
    .o_entry (w_entry)
  );

  always_comb begin
    w_next           = r_state;
    busy             = (r_state != ST_IDLE);
    bus.sample_ready = (r_state == ST_LEARN);
    case (r_state)
      ST_IDLE:   if (learn_start) w_next = ST_CLEAR;
      ST_CLEAR:  if (w_last_idx)  w_next = ST_LEARN;
      ST_LEARN:  if (learn_stop)  w_next = ST_COMMIT;
      ST_COMMIT: if (w_last_idx)  w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_wr_en        <= 1'b0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
      r_done         <= 1'b0;
      r_commit_count <= '0;
    end else begin
      r_state <= w_next;
      // The 6-bit index wraps to 0 on the last slot, ready for the next sweep.
      if (r_state == ST_CLEAR || r_state == ST_COMMIT) r_idx <= r_idx + 1'b1;
      else                                             r_idx <= '0;
      r_wr_en <= w_hit;
      if (w_hit) begin
        r_wr_addr <= r_idx;
        r_wr_data <= w_entry;
      end
      r_done <= (r_state == ST_DONE);
      if (r_state == ST_LEARN && w_next == ST_COMMIT) r_commit_count <= '0;
      else if (w_hit)                                 r_commit_count <= r_commit_count + 1'b1;
    end
  end

  // Statistics are cleared by the CLEAR sweep, not by reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == ST_CLEAR) begin
        r_min[r_idx] <= '1;
        r_max[r_idx] <= '0;
        r_cnt[r_idx] <= '0;
      end else if (w_accept) begin
        if (bus.sample_cycles < r_min[bus.sample_id]) r_min[bus.sample_id] <= bus.sample_cycles;
        if (bus.sample_cycles > r_max[bus.sample_id]) r_max[bus.sample_id] <= bus.sample_cycles;
        if (r_cnt[bus.sample_id] != '1) r_cnt[bus.sample_id] <= r_cnt[bus.sample_id] + 1'b1;
      end
    end
  end

  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  assign done        = r_done;
  assign commit_count = r_commit_count;
endmodule

// File: tb/tb_signature_learner.sv
// tb/tb_signature_learner.sv - randomized and directed self-checking bench for signature_learner
module tb_signature_learner;
  import signature_learner_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          learn_start = 1'b0;
  logic          learn_stop = 1'b0;
  logic          busy;
  logic          done;
  logic [ID_W:0] commit_count;

  signature_learner_if bus ();

  always #5 clk = ~clk;

  signature_learner dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .learn_start  (learn_start),
    .learn_stop   (learn_stop),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .commit_count (commit_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  int unsigned m_q [N_ENTRIES][$];
  int unsigned exp_addr[$];
  logic [31:0] exp_data[$];
  int unsigned got_addr[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_entry(input int unsigned mn, input int unsigned mx);
    int unsigned e;
    int unsigned t;
    logic [7:0]  f;
    e = (mn + mx) / 2;
    t = mx - e + MARGIN;
    f = 8'h01;
    if (t > 255) begin
      t = 255;
      f = 8'h03;
    end
    return {16'(e), 8'(t), f};
  endfunction

  task automatic build_expected();
    int unsigned mn, mx;
    exp_addr.delete();
    exp_data.delete();
    for (int id = 0; id < N_ENTRIES; id++) begin
      if (m_q[id].size() >= MIN_SAMPLES) begin
        mn = 32'hFFFF_FFFF;
        mx = 0;
        foreach (m_q[id][k]) begin
          if (m_q[id][k] < mn) mn = m_q[id][k];
          if (m_q[id][k] > mx) mx = m_q[id][k];
        end
        exp_addr.push_back(id);
        exp_data.push_back(model_entry(mn, mx));
      end
    end
  endtask

  task automatic start_learn(input string tag);
    int k;
    for (int i = 0; i < N_ENTRIES; i++) m_q[i].delete();
    learn_start = 1'b1;
    tick();
    learn_start = 1'b0;
    k = 0;
    while (!bus.sample_ready && k < 200) begin
      tick();
      k++;
    end
    check({tag, ":clear_len"}, k, N_ENTRIES);
  endtask

  task automatic send(input int unsigned id, input int unsigned cyc, input logic stop);
    bus.sample_valid  = 1'b1;
    bus.sample_id     = ID_W'(id);
    bus.sample_cycles = CYC_W'(cyc);
    learn_stop        = stop;
    m_q[id].push_back(cyc & 32'hFFFF);
    tick();
    bus.sample_valid  = 1'b0;
    learn_stop        = 1'b0;
  endtask

  task automatic stop_pulse();
    learn_stop = 1'b1;
    tick();
    learn_stop = 1'b0;
  endtask

  // Called right after the edge that sampled learn_stop; that edge is cycle 0.
  task automatic run_commit(input string tag);
    int done_cyc;
    int n;
    build_expected();
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    done_cyc = -1;
    for (int c = 1; c <= N_ENTRIES + 10; c++) begin
      tick();
      if (bus.wr_en) begin
        got_addr.push_back(bus.wr_addr);
        got_data.push_back(bus.wr_data);
        got_cyc.push_back(c);
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    check({tag, ":n_writes"}, got_addr.size(), exp_addr.size());
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s:addr%0d", tag, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s:data%0d", tag, i), got_data[i], exp_data[i]);
      check($sformatf("%s:slot%0d", tag, i), got_cyc[i], exp_addr[i] + 1);
    end
    check({tag, ":done_cycle"}, done_cyc, N_ENTRIES + 1);
    check({tag, ":commit_count"}, commit_count, exp_addr.size());
    check({tag, ":busy_after"}, busy, 1'b0);
    tick();
    check({tag, ":done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int n_wr;
    bus.sample_valid  = 1'b0;
    bus.sample_id     = '0;
    bus.sample_cycles = '0;

    // Reset
    tick();
    tick();
    check("rst:wr_en", bus.wr_en, 1'b0);
    check("rst:busy", busy, 1'b0);
    check("rst:done", done, 1'b0);
    check("rst:sample_ready", bus.sample_ready, 1'b0);
    check("rst:commit_count", commit_count, 0);
    rst_n = 1'b1;
    tick();
    stop_pulse();
    check("idle:stop_ignored", busy, 1'b0);

    // Single ID with spread 10..14
    start_learn("t2");
    send(5, 10, 0); send(5, 12, 0); send(5, 14, 0); send(5, 12, 0);
    learn_start = 1'b1;
    tick();
    learn_start = 1'b0;
    check("t2:start_ignored", bus.sample_ready, 1'b1);
    stop_pulse();
    run_commit("t2");
    if (got_data.size() > 0) check("t2:const_data", got_data[0], {16'd12, 8'd4, 8'h01});

    // Too few samples for ID7, saturated tolerance for ID9
    start_learn("t34");
    send(7, 9, 0); send(9, 0, 0); send(7, 9, 0); send(9, 1000, 0);
    send(9, 1000, 0); send(7, 9, 0); send(9, 1000, 0);
    stop_pulse();
    run_commit("t34");
    if (got_data.size() > 0) check("t34:const_data", got_data[0], {16'd500, 8'd255, 8'h03});

    // Back-to-back same ID, stop coincident with last sample
    start_learn("t5");
    send(3, 20, 0); send(3, 5, 0); send(3, 30, 0); send(3, 7, 1);
    run_commit("t5");
    if (got_data.size() > 0) check("t5:const_data", got_data[0], {16'd17, 8'd15, 8'h01});

    // Reset in the middle of a commit sweep
    start_learn("t6");
    for (int i = 0; i < 4; i++) send(5, 40 + i, 0);
    for (int i = 0; i < 4; i++) send(30, 70 + i, 0);
    stop_pulse();
    n_wr = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus.wr_en) n_wr++;
    end
    check("t6:writes_before_rst", n_wr, 1);
    rst_n = 1'b0;
    tick();
    check("t6:wr_en_rst", bus.wr_en, 1'b0);
    check("t6:busy_rst", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    start_learn("t6b");
    for (int i = 0; i < 4; i++) send(40, 100 + 3 * i, 0);
    stop_pulse();
    run_commit("t6b");

    // Randomized training windows
    for (int r = 0; r < 3; r++) begin
      logic last_stop;
      start_learn($sformatf("rnd%0d", r));
      if (r == 0) for (int i = 0; i < 300; i++) send(2, $urandom_range(50, 60), 0);
      for (int i = 0; i < 150; i++) begin
        int unsigned id, cyc;
        id  = $urandom_range(0, 15) + 16 * (r % 2);
        cyc = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 65535) : $urandom_range(100, 140);
        last_stop = (i == 149) && ($urandom_range(0, 1) == 1);
        send(id, cyc, last_stop);
        if ($urandom_range(0, 3) == 0) tick();
      end
      if (!last_stop) stop_pulse();
      run_commit($sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
